// File: rtl/phase_clock_pkg.sv
// Shared state encoding and default parameter values for the phase_clock block.
package phase_clock_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_RUN      = 2'd1;
   localparam state_t ST_STOPPING = 2'd2;
   localparam state_t ST_STEP     = 2'd3;

   localparam int PHASES_DEF   = 4;
   localparam int DIV_W_DEF    = 8;
   localparam int WS_PHASE_DEF = 2;

endpackage

// File: rtl/clk_prescaler.sv
// Programmable prescaler: registered one-clk tick every div+1 enabled cycles.
// div is captured at clear and at each wrap, so mid-interval changes apply to the next interval.
module clk_prescaler
   import phase_clock_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] div_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count <= '0;
         div_q <= '0;
         tick  <= 1'b0;
      end else if (clr) begin
         count <= '0;
         div_q <= div;
         tick  <= 1'b0;
      end else if (en) begin
         if (count == div_q) begin
            count <= '0;
            div_q <= div;
            tick  <= 1'b1;
         end else begin
            count <= count + DIV_W'(1);
            tick  <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/phase_clock.sv
// Multi-phase machine clock: one-hot phase ring advanced by a prescaled tick, with run/stop FSM.
// Optional single-cycle step mode is built only when PHASE_CLOCK_STEP_EN is defined.
module phase_clock
   import phase_clock_pkg::*;
#(
   parameter int PHASES   = PHASES_DEF,
   parameter int DIV_W    = DIV_W_DEF,
   parameter int WS_PHASE = WS_PHASE_DEF
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              stop,
`ifdef PHASE_CLOCK_STEP_EN
   input  logic              step,
`endif
   input  logic [DIV_W-1:0]  div,
   output logic              running,
   output logic [PHASES-1:0] phase,
   output logic              tick,
   output logic              sc,
   output logic              ws
);

   state_t state;
   state_t state_next;
   logic   cycle_end;
   logic   pre_en;
   logic   pre_clr;

   // A tick seen while the ring sits on its last phase closes the machine cycle.
   assign cycle_end = tick & phase[PHASES-1];

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start && !stop)
               state_next = ST_RUN;
`ifdef PHASE_CLOCK_STEP_EN
            else if (step && !start && !stop)
               state_next = ST_STEP;
`endif
         end
         ST_RUN: begin
            if (stop)
               state_next = ST_STOPPING;
         end
         ST_STOPPING: begin
            if (cycle_end)
               state_next = ST_IDLE;
         end
`ifdef PHASE_CLOCK_STEP_EN
         ST_STEP: begin
            if (stop)
               state_next = cycle_end ? ST_IDLE : ST_STOPPING;
            else if (start)
               state_next = ST_RUN;
            else if (cycle_end)
               state_next = ST_IDLE;
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Holding the prescaler clear on the exit edge keeps a stray tick out of IDLE.
   assign pre_en  = (state != ST_IDLE);
   assign pre_clr = (state == ST_IDLE) || (state_next == ST_IDLE);

   clk_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk  (clk),
      .nrst (nrst),
      .en   (pre_en),
      .clr  (pre_clr),
      .div  (div),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         phase <= PHASES'(1);
      else if (tick)
         phase <= {phase[PHASES-2:0], phase[PHASES-1]};
   end

   assign running = (state != ST_IDLE);
   assign sc      = cycle_end;
   assign ws      = tick & phase[WS_PHASE];

endmodule

// File: tb/tb_phase_clock.sv
// Directed self-checking bench for phase_clock (PHASES=4, WS_PHASE=2).
module tb_phase_clock;

   logic       clk;
   logic       nrst;
   logic       start;
   logic       stop;
`ifdef PHASE_CLOCK_STEP_EN
   logic       step;
`endif
   logic [7:0] div;
   logic       running;
   logic [3:0] phase;
   logic       tick;
   logic       sc;
   logic       ws;
   logic [7:0] obs;

   int checks;
   int failures;

   phase_clock #(
      .PHASES   (4),
      .DIV_W    (8),
      .WS_PHASE (2)
   ) dut (
      .clk     (clk),
      .nrst    (nrst),
      .start   (start),
      .stop    (stop),
`ifdef PHASE_CLOCK_STEP_EN
      .step    (step),
`endif
      .div     (div),
      .running (running),
      .phase   (phase),
      .tick    (tick),
      .sc      (sc),
      .ws      (ws)
   );

   assign obs = {running, phase, tick, sc, ws};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      int n;
      n    = 0;
      stop = 1'b1;
      while (running && n < 60) begin
         cyc();
         n++;
      end
      stop = 1'b0;
      checks++;
      if (running !== 1'b0 || phase !== 4'd1 || tick !== 1'b0) begin
         failures++;
         $display("FAIL idle_return got running=%0b phase=%0h tick=%0b exp running=0 phase=1 tick=0",
                  running, phase, tick);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b1;
      #2;
      nrst = 1'b0;
      #1;
      checks++;
      if (obs !== {1'b0, 4'd1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got=%02h exp=%02h", obs, {1'b0, 4'd1, 3'b000});
      end
      cyc();
      cyc();
      nrst = 1'b1;
      cyc();
      checks++;
      if (obs !== {1'b0, 4'd1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_release got=%02h exp=%02h", obs, {1'b0, 4'd1, 3'b000});
      end
   endtask

   task automatic test_run_div0();
      logic [7:0] exp;
      logic [3:0] ep;
      div   = 8'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      checks++;
      if (obs !== {1'b1, 4'd1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL run_first got=%02h exp=%02h", obs, {1'b1, 4'd1, 3'b000});
      end
      for (int i = 0; i < 8; i++) begin
         cyc();
         ep  = 4'd1 << (i % 4);
         exp = {1'b1, ep, 1'b1, (i % 4) == 3, (i % 4) == 2};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL run_div0[%0d] got=%02h exp=%02h", i, obs, exp);
         end
      end
      go_idle();
   endtask

   task automatic test_prescaler();
      logic [5:0] exp;
      logic [3:0] ep;
      logic       et;
      div   = 8'd3;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (k <= 4)       ep = 4'd1;
         else if (k <= 8)  ep = 4'd2;
         else if (k <= 10) ep = 4'd4;
         else              ep = 4'd8;
         et  = (k == 4) || (k == 8) || (k == 10) || (k == 12);
         exp = {ep, et, k == 12};
         checks++;
         if ({phase, tick, sc} !== exp) begin
            failures++;
            $display("FAIL prescaler[%0d] got=%02h exp=%02h", k, {phase, tick, sc}, exp);
         end
         if (k == 5)
            div = 8'd1;
      end
      go_idle();
   endtask

   task automatic test_stop();
      logic [7:0] exp [4];
      exp[0] = {1'b1, 4'd4, 1'b1, 1'b0, 1'b1};
      exp[1] = {1'b1, 4'd8, 1'b1, 1'b1, 1'b0};
      exp[2] = {1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
      exp[3] = {1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
      div   = 8'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      checks++;
      if (obs !== {1'b1, 4'd2, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL stop_pre got=%02h exp=%02h", obs, {1'b1, 4'd2, 3'b100});
      end
      stop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         stop = 1'b0;
         checks++;
         if (obs !== exp[i]) begin
            failures++;
            $display("FAIL stop_seq[%0d] got=%02h exp=%02h", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_stop_at_sc();
      logic [7:0] exp;
      logic [3:0] ep;
      div   = 8'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      checks++;
      if (obs !== {1'b1, 4'd8, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL stop_sc_pre got=%02h exp=%02h", obs, {1'b1, 4'd8, 3'b110});
      end
      start = 1'b1;
      stop  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         start = 1'b0;
         stop  = 1'b0;
         ep    = 4'd1 << i;
         exp   = {1'b1, ep, 1'b1, i == 3, i == 2};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL stop_sc_cycle[%0d] got=%02h exp=%02h", i, obs, exp);
         end
      end
      cyc();
      checks++;
      if (obs !== {1'b0, 4'd1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL stop_sc_idle got=%02h exp=%02h", obs, {1'b0, 4'd1, 3'b000});
      end
   endtask

   task automatic test_start_stop_both();
      int n;
      start = 1'b1;
      stop  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if (obs !== {1'b0, 4'd1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL both_idle[%0d] got=%02h exp=%02h", i, obs, {1'b0, 4'd1, 3'b000});
         end
      end
      div   = 8'd1;
      stop  = 1'b0;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      stop = 1'b1;
      cyc();
      stop  = 1'b0;
      start = 1'b1;
      n     = 0;
      while (running && n < 20) begin
         cyc();
         n++;
      end
      start = 1'b0;
      checks++;
      if (running !== 1'b0 || phase !== 4'd1) begin
         failures++;
         $display("FAIL stopping_ignores_start got running=%0b phase=%0h exp running=0 phase=1",
                  running, phase);
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      int n;
      div   = 8'd2;
      start = 1'b1;
      cyc();
      start = 1'b0;
      n     = 0;
      while (!(phase == 4'd4 && tick == 1'b0) && n < 40) begin
         cyc();
         n++;
      end
      checks++;
      if (phase !== 4'd4) begin
         failures++;
         $display("FAIL reset_mid_reach got phase=%0h exp phase=4", phase);
      end
      #2;
      nrst = 1'b0;
      #1;
      checks++;
      if (obs !== {1'b0, 4'd1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid_async got=%02h exp=%02h", obs, {1'b0, 4'd1, 3'b000});
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if (obs !== {1'b0, 4'd1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_hold[%0d] got=%02h exp=%02h", i, obs, {1'b0, 4'd1, 3'b000});
         end
      end
      #2;
      nrst = 1'b1;
      cyc();
      checks++;
      if (obs !== {1'b0, 4'd1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid_release got=%02h exp=%02h", obs, {1'b0, 4'd1, 3'b000});
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      checks++;
      if (obs !== {1'b1, 4'd1, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL restart_first got=%02h exp=%02h", obs, {1'b1, 4'd1, 3'b000});
      end
      cyc();
      cyc();
      cyc();
      checks++;
      if (obs !== {1'b1, 4'd1, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL restart_tick got=%02h exp=%02h", obs, {1'b1, 4'd1, 3'b100});
      end
      go_idle();
   endtask

`ifdef PHASE_CLOCK_STEP_EN
   task automatic test_step();
      int nt;
      int nsc;
      int nws;
      nt   = 0;
      nsc  = 0;
      nws  = 0;
      div  = 8'd1;
      step = 1'b1;
      cyc();
      step = 1'b0;
      checks++;
      if (running !== 1'b1) begin
         failures++;
         $display("FAIL step_enter got running=%0b exp 1", running);
      end
      for (int i = 0; i < 12; i++) begin
         cyc();
         nt  += int'(tick);
         nsc += int'(sc);
         nws += int'(ws);
      end
      checks++;
      if (nt != 4 || nsc != 1 || nws != 1 || running !== 1'b0 || phase !== 4'd1) begin
         failures++;
         $display("FAIL step_cycle got ticks=%0d sc=%0d ws=%0d running=%0b phase=%0h exp 4 1 1 0 1",
                  nt, nsc, nws, running, phase);
      end
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc();
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 20; i++) cyc();
      checks++;
      if (running !== 1'b1) begin
         failures++;
         $display("FAIL step_promote got running=%0b exp 1", running);
      end
      go_idle();
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      nrst     = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
`ifdef PHASE_CLOCK_STEP_EN
      step     = 1'b0;
`endif
      div      = 8'd0;
      test_reset();
      test_run_div0();
      test_prescaler();
      test_stop();
      test_stop_at_sc();
      test_start_stop_both();
      test_reset_mid();
`ifdef PHASE_CLOCK_STEP_EN
      test_step();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
